// File: rtl/pcie_seq_pkg.sv
// Shared definitions for the PCIe link bring-up sequencer: state encoding
// (also driven onto the LEDs) and the default LTSSM code for L0.
package pcie_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD     = 3'd1,
    ST_WAIT_HIP = 3'd2,
    ST_WAIT_L0  = 3'd3,
    ST_LINK_UP  = 3'd4,
    ST_RETRY    = 3'd5,
    ST_FAULT    = 3'd6
  } seq_state_e;

  localparam logic [4:0] LTSSM_L0_ENC = 5'h0F;
  localparam int         TIMER_W      = 24;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for signals crossing into the clk_u59 domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_u59,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both stages sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk_u59 or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pcie_link_sequencer.sv
// PCIe hard-IP bring-up sequencer: holds the HIP in reset after PERST#,
// waits for reset release and L0, retries on timeout and latches FAULT.
module pcie_link_sequencer
  import pcie_seq_pkg::*;
#(
  parameter int         NPOR_HOLD_CYCLES    = 1000,
  parameter int         LINK_TIMEOUT_CYCLES = 10_000_000,
  parameter int         MAX_RETRIES         = 3,
  parameter logic [4:0] LTSSM_L0            = LTSSM_L0_ENC
) (
  input  logic       clk_u59,
  input  logic       rstn,
  input  logic       pcie1_perstn,
  input  logic       hip_reset_status,
  input  logic [4:0] hip_ltssm,
  input  logic       sw_retrain,
  output logic       hip_npor,
  output logic       link_up,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] link_drop_count,
  output logic [2:0] seq_state
);

  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(NPOR_HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LINK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]         LAST_RETRY   = 2'(MAX_RETRIES - 1);

  logic               perst_s;
  logic               hip_rst_s;
  logic [4:0]         ltssm_s;
  logic [4:0]         ltssm_prev;
  logic               ltssm_stable;
  logic [TIMER_W-1:0] timer;
  seq_state_e         state;
  seq_state_e         state_nxt;

  sync2 #(.WIDTH(1)) u_sync_perst (
    .clk_u59 (clk_u59), .rstn (rstn), .d (pcie1_perstn),     .q (perst_s));
  sync2 #(.WIDTH(1)) u_sync_hiprst (
    .clk_u59 (clk_u59), .rstn (rstn), .d (hip_reset_status), .q (hip_rst_s));
  sync2 #(.WIDTH(5)) u_sync_ltssm (
    .clk_u59 (clk_u59), .rstn (rstn), .d (hip_ltssm),        .q (ltssm_s));

  // A multi-bit LTSSM code may be caught mid-transition; only trust it once it
  // has read the same on two consecutive cycles.
  assign ltssm_stable = (ltssm_s == ltssm_prev);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (!perst_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     state_nxt = ST_HOLD;
        ST_HOLD:     if (timer == HOLD_LAST) state_nxt = ST_WAIT_HIP;
        ST_WAIT_HIP: begin
          if (!hip_rst_s)                 state_nxt = ST_WAIT_L0;
          else if (timer == TIMEOUT_LAST) state_nxt = ST_RETRY;
        end
        ST_WAIT_L0: begin
          if (ltssm_stable && ltssm_s == LTSSM_L0) state_nxt = ST_LINK_UP;
          else if (timer == TIMEOUT_LAST)          state_nxt = ST_RETRY;
        end
        ST_LINK_UP: begin
          if (sw_retrain)                               state_nxt = ST_RETRY;
          else if (ltssm_stable && ltssm_s != LTSSM_L0) state_nxt = ST_WAIT_L0;
        end
        ST_RETRY:    state_nxt = (retry_count == LAST_RETRY) ? ST_FAULT : ST_HOLD;
        ST_FAULT:    state_nxt = ST_FAULT;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state_nxt so they change together with the state.
  always_ff @(posedge clk_u59 or negedge rstn) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      seq_state       <= 3'(ST_IDLE);
      hip_npor        <= 1'b0;
      link_up         <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= 2'd0;
      link_drop_count <= 8'd0;
      timer           <= '0;
      ltssm_prev      <= 5'd0;
    end else begin
      state      <= state_nxt;
      seq_state  <= 3'(state_nxt);
      hip_npor   <= state_nxt inside {ST_WAIT_HIP, ST_WAIT_L0, ST_LINK_UP};
      link_up    <= (state_nxt == ST_LINK_UP);
      fault      <= (state_nxt == ST_FAULT);
      ltssm_prev <= ltssm_s;

      // The attempt budget spans HIP release and link training together.
      if (state_nxt != state && !(state == ST_WAIT_HIP && state_nxt == ST_WAIT_L0))
        timer <= '0;
      else if (state inside {ST_HOLD, ST_WAIT_HIP, ST_WAIT_L0})
        timer <= timer + 1'b1;

      if (!perst_s)
        retry_count <= 2'd0;
      else if (state == ST_RETRY && retry_count != 2'd3)
        retry_count <= retry_count + 2'd1;

      if (state == ST_LINK_UP && state_nxt == ST_WAIT_L0 && link_drop_count != 8'hFF)
        link_drop_count <= link_drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pcie_link_sequencer.sv
// Directed bench for pcie_link_sequencer with a queue of expected values.
module tb_pcie_link_sequencer;

  localparam int HOLD = 1000;
  localparam int TO   = 2000;

  logic       clk_u59 = 1'b0;
  logic       rstn;
  logic       pcie1_perstn;
  logic       hip_reset_status;
  logic [4:0] hip_ltssm;
  logic       sw_retrain;
  logic       hip_npor;
  logic       link_up;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] link_drop_count;
  logic [2:0] seq_state;

  pcie_link_sequencer #(
    .NPOR_HOLD_CYCLES    (HOLD),
    .LINK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (3),
    .LTSSM_L0            (5'h0F)
  ) dut (
    .clk_u59          (clk_u59),
    .rstn             (rstn),
    .pcie1_perstn     (pcie1_perstn),
    .hip_reset_status (hip_reset_status),
    .hip_ltssm        (hip_ltssm),
    .sw_retrain       (sw_retrain),
    .hip_npor         (hip_npor),
    .link_up          (link_up),
    .fault            (fault),
    .retry_count      (retry_count),
    .link_drop_count  (link_drop_count),
    .seq_state        (seq_state)
  );

  always #5 clk_u59 = ~clk_u59;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_u59);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int n;
    n = 0;
    while (seq_state !== st && n < budget) begin
      tick(1);
      n++;
    end
    push(tag, 32'(st));
    check(32'(seq_state));
  endtask

  task automatic cycles_to_npor(input logic level, input int budget, output int n);
    n = 0;
    while (hip_npor !== level && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int pulses;

    rstn             = 1'b0;
    pcie1_perstn     = 1'b0;
    hip_reset_status = 1'b1;
    hip_ltssm        = 5'h00;
    sw_retrain       = 1'b0;
    tick(3);

    push("rst_state", 0);    check(32'(seq_state));
    push("rst_npor", 0);     check(32'(hip_npor));
    push("rst_link_up", 0);  check(32'(link_up));
    push("rst_fault", 0);    check(32'(fault));
    push("rst_retry", 0);    check(32'(retry_count));
    push("rst_drops", 0);    check(32'(link_drop_count));

    rstn = 1'b1;
    tick(3);
    push("idle_no_perst", 0); check(32'(seq_state));

    // Bring-up: 2-flop sync + 1 FSM cycle + 1000 hold cycles.
    pcie1_perstn = 1'b1;
    push("npor_rise_cycles", 1003);
    cycles_to_npor(1'b1, 1100, n);
    check(32'(n));
    push("wait_hip_entry", 2); check(32'(seq_state));
    tick(50);
    hip_reset_status = 1'b0;
    tick(450);
    hip_ltssm = 5'h0F;
    wait_state("link_up_state", 3'd4, 20);
    push("link_up_flag", 1);  check(32'(link_up));
    push("bringup_retry", 0); check(32'(retry_count));

    // One-cycle glitch off L0 must be ignored.
    hip_ltssm = 5'h11;
    tick(1);
    hip_ltssm = 5'h0F;
    tick(6);
    push("glitch_state", 4); check(32'(seq_state));
    push("glitch_drops", 0); check(32'(link_drop_count));

    // Held three cycles: a real L0 exit.
    hip_ltssm = 5'h11;
    tick(3);
    hip_ltssm = 5'h0F;
    tick(1);
    push("drop_state", 3);   check(32'(seq_state));
    push("drop_link_up", 0); check(32'(link_up));
    push("drop_count", 1);   check(32'(link_drop_count));
    wait_state("relink", 3'd4, 20);

    // sw_retrain coincident with a qualified L0 exit.
    hip_ltssm = 5'h11;
    tick(3);
    sw_retrain = 1'b1;
    tick(1);
    sw_retrain = 1'b0;
    push("retrain_state", 5); check(32'(seq_state));
    push("retrain_npor", 0);  check(32'(hip_npor));
    push("retrain_drops", 1); check(32'(link_drop_count));
    tick(1);
    push("retrain_retry", 1); check(32'(retry_count));
    push("retrain_hold", 1);  check(32'(seq_state));

    // PERST# low while training.
    wait_state("reach_wait_l0", 3'd3, 1100);
    pcie1_perstn = 1'b0;
    push("perst_npor_within_3", 1);
    cycles_to_npor(1'b0, 10, n);
    check(32'(n >= 1 && n <= 3));
    push("perst_idle", 0);  check(32'(seq_state));
    push("perst_retry", 0); check(32'(retry_count));

    // L0 never reached: three timeouts end in FAULT.
    pcie1_perstn = 1'b1;
    n      = 0;
    pulses = 0;
    while (fault !== 1'b1 && n < 12000) begin
      tick(1);
      n++;
      if (seq_state === 3'd5) pulses++;
    end
    push("retry_pulses", 3); check(32'(pulses));
    push("fault_flag", 1);   check(32'(fault));
    push("fault_state", 6);  check(32'(seq_state));
    push("fault_npor", 0);   check(32'(hip_npor));
    push("fault_retry", 3);  check(32'(retry_count));
    tick(20);
    push("fault_sticky", 6); check(32'(seq_state));

    // Short PERST# pulse leaves FAULT.
    pcie1_perstn = 1'b0;
    tick(2);
    pcie1_perstn = 1'b1;
    tick(1);
    push("pulse_idle", 0);  check(32'(seq_state));
    push("pulse_retry", 0); check(32'(retry_count));
    push("pulse_fault", 0); check(32'(fault));

    // Drop counter saturation.
    hip_ltssm = 5'h0F;
    wait_state("relink2", 3'd4, 1100);
    for (int i = 0; i < 256; i++) begin
      hip_ltssm = 5'h11;
      tick(3);
      hip_ltssm = 5'h0F;
      tick(2);
      for (int k = 0; k < 20 && seq_state !== 3'd4; k++) tick(1);
      if (i == 254) begin
        push("drops_255", 255); check(32'(link_drop_count));
      end
    end
    push("drops_saturated", 255); check(32'(link_drop_count));
    push("sat_link_up", 1);        check(32'(link_up));

    // Asynchronous reset between clock edges while the link is up.
    #2;
    rstn = 1'b0;
    #1;
    push("async_npor", 0);  check(32'(hip_npor));
    push("async_drops", 0); check(32'(link_drop_count));
    push("async_state", 0); check(32'(seq_state));
    tick(2);
    rstn = 1'b1;

    // Asynchronous reset in the middle of HOLD.
    wait_state("hold_again", 3'd1, 10);
    tick(100);
    #2;
    rstn = 1'b0;
    #1;
    push("hold_rst_npor", 0);  check(32'(hip_npor));
    push("hold_rst_retry", 0); check(32'(retry_count));
    push("hold_rst_state", 0); check(32'(seq_state));
    tick(2);
    rstn = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_link_sequencer.md
PCIE_LINK_SEQUENCER -- requirements
Module: pcie_link_sequencer

Interface
REQ-001 Parameter NPOR_HOLD_CYCLES, default 1000: cycles hip_npor is held low before each bring-up attempt (10 us at 100 MHz).
REQ-002 Parameter LINK_TIMEOUT_CYCLES, default 10_000_000: per-attempt limit for HIP reset release plus reaching L0 (100 ms).
REQ-003 Parameter MAX_RETRIES, default 3: failed attempts tolerated before FAULT.
REQ-004 Parameter LTSSM_L0, default 5'h0F: LTSSM encoding of L0.
REQ-005 clk_u59  in  1  100 MHz system clock; the only clock in the block.
REQ-006 rstn  in  1  reset, asynchronous assert, active-low.
REQ-007 pcie1_perstn  in  1  PERST# from the slot pin; asynchronous to clk_u59.
REQ-008 hip_reset_status  in  1  HIP core-in-reset flag, high = in reset; asynchronous to clk_u59.
REQ-009 hip_ltssm  in  5  HIP LTSSM state; asynchronous to clk_u59.
REQ-010 sw_retrain  in  1  single-cycle request to re-run bring-up.
REQ-011 hip_npor  out  1  drives the HIP npor input; low = HIP held in reset.
REQ-012 link_up  out  1  high only in state LINK_UP.
REQ-013 fault  out  1  high only in state FAULT.
REQ-014 retry_count  out  2  failed attempts since the last PERST#; saturates at 3.
REQ-015 link_drop_count  out  8  L0 exits while in LINK_UP; saturates at 255.
REQ-016 seq_state  out  3  current state encoding, intended for the LEDs.

Function
REQ-017 Each of pcie1_perstn, hip_reset_status and hip_ltssm SHALL pass through a 2-flop synchronizer before use.
REQ-018 LTSSM qualification: hip_ltssm counts as a value only when the synchronized value is equal on 2 consecutive cycles.
REQ-019 States and encodings: IDLE=0, HOLD=1, WAIT_HIP=2, WAIT_L0=3, LINK_UP=4, RETRY=5, FAULT=6.
REQ-020 One 24-bit timer, cleared on every state entry and incremented in HOLD, WAIT_HIP and WAIT_L0.
REQ-021 IDLE: hip_npor=0; go to HOLD when synchronized PERST# is high.
REQ-022 HOLD: hip_npor=0; go to WAIT_HIP when timer==NPOR_HOLD_CYCLES-1; hip_npor=1 from the WAIT_HIP entry cycle.
REQ-023 WAIT_HIP: go to WAIT_L0 when synchronized hip_reset_status=0; timer keeps counting (not cleared); timer==LINK_TIMEOUT_CYCLES-1 -> RETRY.
REQ-024 WAIT_L0: qualified LTSSM==LTSSM_L0 -> LINK_UP; timer==LINK_TIMEOUT_CYCLES-1 -> RETRY; sw_retrain ignored.
REQ-025 LINK_UP: qualified LTSSM!=LTSSM_L0 -> WAIT_L0, timer cleared, link_drop_count+1 (saturating).
REQ-026 LINK_UP: sw_retrain -> RETRY; if an L0 exit occurs in the same cycle, sw_retrain wins and link_drop_count does not increment.
REQ-027 RETRY lasts 1 cycle: hip_npor=0; retry_count+1 (saturating). Next state is FAULT if the pre-increment retry_count==MAX_RETRIES-1, else HOLD.
REQ-028 FAULT: hip_npor=0, fault=1; exit only via PERST# low or rstn.
REQ-029 Synchronized PERST# low in any state: next state IDLE, retry_count cleared, hip_npor=0 next cycle; this has priority over every other transition. Pin-to-npor latency is at most 3 cycles.
REQ-030 link_drop_count is cleared only by rstn.
REQ-031 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-032 While rstn=0 and on release: state IDLE, hip_npor=0, link_up=0, fault=0, retry_count=0, link_drop_count=0, timer=0, synchronizers=0.
REQ-033 rstn asserted mid-operation SHALL force hip_npor low asynchronously, without waiting for a clock edge.

Structure
REQ-034 Shared package pcie_seq_pkg holds the state enumeration and the LTSSM_L0 constant.
REQ-035 Sub-module sync2 (2-flop synchronizer, width parameter) is instantiated for all three asynchronous inputs; the FSM, timer and counters stay in the top module.

Verification
REQ-036 PERST# rises, HIP releases after 50 cycles, LTSSM=0x0F after 500 cycles -> hip_npor rises at ~1003 cycles (3-cycle sync + 1000 hold), link_up=1, retry_count=0.
REQ-037 LTSSM never reaches L0 (LINK_TIMEOUT_CYCLES=2000) -> three RETRY pulses, retry_count=3, FAULT with fault=1 and hip_npor=0; a PERST# low pulse returns to IDLE with retry_count=0.
REQ-038 In LINK_UP, LTSSM glitches to 0x11 for 1 cycle -> no exit; 0x11 held 3 cycles -> WAIT_L0, link_drop_count=1, link_up=0.
REQ-039 sw_retrain in the same cycle as a qualified L0 exit -> RETRY, link_drop_count unchanged, retry_count=1.
REQ-040 PERST# low during WAIT_L0 -> hip_npor=0 within 3 cycles, IDLE; rstn low mid-HOLD -> hip_npor=0 immediately, all counters 0.
REQ-041 256 forced L0 drops -> link_drop_count saturates at 255.
